// File: rtl/spm_wb_pkg.sv
// rtl/spm_wb_pkg.sv - shared constants for the SPM Wishbone driver
package spm_wb_pkg;

    localparam logic [31:0] X_OFF  = 32'd0;
    localparam logic [31:0] Y_OFF  = 32'd4;
    localparam logic [31:0] P0_OFF = 32'd8;
    localparam logic [31:0] P1_OFF = 32'd12;

    localparam int DEF_WAIT_CYCLES = 72;
    localparam int DEF_ACK_TIMEOUT = 16;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_WR_X  = 3'd1;
    localparam state_t S_WR_Y  = 3'd2;
    localparam state_t S_WAIT  = 3'd3;
    localparam state_t S_RD_LO = 3'd4;
    localparam state_t S_GAP   = 3'd5;
    localparam state_t S_RD_HI = 3'd6;
    localparam state_t S_RESP  = 3'd7;

endpackage

// File: rtl/spm_wb_xfer.sv
// rtl/spm_wb_xfer.sv - single Wishbone classic transfer engine with ack timeout
module spm_wb_xfer #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        xfer_we,
    input  logic [31:0] xfer_adr,
    input  logic [31:0] xfer_dat,
    output logic        done,
    output logic        timeout,
    output logic [31:0] rdata,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

    logic [15:0] tcnt;

    // ack only counts while our strobe is up; anything else is a stray
    assign done    = wbm_stb_o & wbm_ack_i;
    assign timeout = wbm_stb_o & ~wbm_ack_i & (tcnt == TO_LAST);
    assign rdata   = wbm_dat_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'h0;
            wbm_adr_o <= 32'h0;
            wbm_dat_o <= 32'h0;
            tcnt      <= 16'h0;
        end else begin
            wbm_sel_o <= 4'hF;
            if (start) begin
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                wbm_we_o  <= xfer_we;
                wbm_adr_o <= xfer_adr;
                wbm_dat_o <= xfer_we ? xfer_dat : 32'h0;
                tcnt      <= 16'h0;
            end else if (done || timeout) begin
                wbm_cyc_o <= 1'b0;
                wbm_stb_o <= 1'b0;
                wbm_we_o  <= 1'b0;
                wbm_dat_o <= 32'h0;
            end else if (wbm_stb_o) begin
                tcnt <= tcnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/spm_wb_driver.sv
// rtl/spm_wb_driver.sv - sequences X/Y writes and product reads to the SPM peripheral
module spm_wb_driver
    import spm_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int          ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_x,
    input  logic [31:0] req_y,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_prod,
    output logic        rsp_err,
    output logic        busy,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    state_t      state;
    state_t      gap_next;
    logic [31:0] y_r;
    logic [31:0] prod_lo;
    logic [15:0] wcnt;

    logic        start;
    logic        s_we;
    logic [31:0] s_adr;
    logic [31:0] s_dat;
    logic        xfer_done;
    logic        xfer_timeout;
    logic [31:0] xfer_rdata;

    // Transfer launches are decided combinationally so stb rises on the same
    // edge the FSM leaves IDLE, GAP or WAIT.
    always_comb begin
        start = 1'b0;
        s_we  = 1'b0;
        s_adr = 32'h0;
        s_dat = 32'h0;
        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    start = 1'b1;
                    s_we  = 1'b1;
                    s_adr = BASE_ADDR + X_OFF;
                    s_dat = req_x;
                end
            end
            S_GAP: begin
                start = 1'b1;
                if (gap_next == S_WR_Y) begin
                    s_we  = 1'b1;
                    s_adr = BASE_ADDR + Y_OFF;
                    s_dat = y_r;
                end else begin
                    s_adr = BASE_ADDR + P1_OFF;
                end
            end
            S_WAIT: begin
                if (wcnt == 16'd1) begin
                    start = 1'b1;
                    s_adr = BASE_ADDR + P0_OFF;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            gap_next  <= S_IDLE;
            y_r       <= 32'h0;
            prod_lo   <= 32'h0;
            wcnt      <= 16'h0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_prod  <= 64'h0;
            rsp_err   <= 1'b0;
        end else if (xfer_timeout) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_prod  <= 64'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        y_r       <= req_y;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_WR_X;
                    end
                end
                S_WR_X: begin
                    if (xfer_done) begin
                        gap_next <= S_WR_Y;
                        state    <= S_GAP;
                    end
                end
                S_WR_Y: begin
                    if (xfer_done) begin
                        wcnt  <= 16'(WAIT_CYCLES);
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    wcnt <= wcnt - 16'd1;
                    if (wcnt == 16'd1) state <= S_RD_LO;
                end
                S_RD_LO: begin
                    if (xfer_done) begin
                        prod_lo  <= xfer_rdata;
                        gap_next <= S_RD_HI;
                        state    <= S_GAP;
                    end
                end
                S_GAP: state <= gap_next;
                S_RD_HI: begin
                    if (xfer_done) begin
                        rsp_prod  <= {xfer_rdata, prod_lo};
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    spm_wb_xfer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_xfer (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .xfer_we   (s_we),
        .xfer_adr  (s_adr),
        .xfer_dat  (s_dat),
        .done      (xfer_done),
        .timeout   (xfer_timeout),
        .rdata     (xfer_rdata),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i)
    );

endmodule

// File: tb/tb_spm_wb_driver.sv
// tb/tb_spm_wb_driver.sv - self-checking bench for spm_wb_driver with an SPM slave model
module tb_spm_wb_driver;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int W = 72;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_x = 32'h0;
    logic [31:0] req_y = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_prod;
    logic        rsp_err;
    logic        busy;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spm_wb_driver dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_prod(rsp_prod), .rsp_err(rsp_err),
        .busy(busy),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // SPM peripheral model: registered ack, product computed arithmetically
    typedef struct packed {logic we; logic [31:0] adr; logic [31:0] dat;} txn_t;
    txn_t        log_q[$];
    logic        slave_ack = 1'b0;
    logic        stray = 1'b0;
    logic        stray_en = 1'b0;
    logic        mute_y = 1'b0;
    logic [31:0] mem_x = 32'h0;
    logic [31:0] mem_y = 32'h0;
    logic [63:0] mem_p;

    assign mem_p     = {32'h0, mem_x} * {32'h0, mem_y};
    assign wbm_ack_i = slave_ack | stray;
    assign wbm_dat_i = (wbm_adr_o == BASE + 32'd8)  ? mem_p[31:0] :
                       (wbm_adr_o == BASE + 32'd12) ? mem_p[63:32] : 32'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            slave_ack <= 1'b0;
        end else begin
            slave_ack <= wbm_cyc_o && wbm_stb_o && !slave_ack &&
                         !(mute_y && wbm_we_o && wbm_adr_o == BASE + 32'd4);
            if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
                log_q.push_back({wbm_we_o, wbm_adr_o, wbm_we_o ? wbm_dat_o : wbm_dat_i});
                if (wbm_we_o && wbm_adr_o == BASE)         mem_x <= wbm_dat_o;
                if (wbm_we_o && wbm_adr_o == BASE + 32'd4) mem_y <= wbm_dat_o;
            end
        end
    end

    // edges elapsed since the most recent accepting edge
    int lat = 0;
    always @(posedge clk) begin
        if (!rst && req_valid && req_ready) lat <= 0;
        else if (lat < 100000)              lat <= lat + 1;
    end

    logic        timing_on = 1'b0;
    logic        count_y = 1'b0;
    int          y_stb_cycles = 0;
    logic [63:0] model_prod = 64'h0;
    logic        model_err = 1'b0;

    always @(negedge clk) stray = stray_en && timing_on && (lat == 40);

    // strobe windows of a zero-wait transaction: X, Y, P0, P1 each two cycles
    function automatic logic exp_stb(input int l);
        return (l == 0 || l == 1 || l == 3 || l == 4 ||
                l == W + 5 || l == W + 6 || l == W + 8 || l == W + 9);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (wbm_stb_o) begin
                check("sel_on_xfer", {60'h0, wbm_sel_o}, 64'hF);
                check("cyc_with_stb", {63'h0, wbm_cyc_o}, 64'h1);
            end
            if (!wbm_we_o) check("dat_zero_outside_write", {32'h0, wbm_dat_o}, 64'h0);
            check("busy_vs_ready", {63'h0, busy}, {63'h0, !req_ready});
            if (rsp_valid) begin
                check("rsp_prod", rsp_prod, model_prod);
                check("rsp_err", {63'h0, rsp_err}, {63'h0, model_err});
            end
            if (timing_on && lat <= W + 10) begin
                check("stb_timing", {63'h0, wbm_stb_o}, {63'h0, exp_stb(lat)});
                check("rsp_valid_timing", {63'h0, rsp_valid}, {63'h0, lat >= W + 10});
            end
            if (count_y && wbm_stb_o && wbm_we_o && wbm_adr_o == BASE + 32'd4)
                y_stb_cycles++;
        end
    end

    task automatic accept_req(input logic [31:0] x, input logic [31:0] y, input logic timed);
        int n;
        @(negedge clk);
        req_x = x;
        req_y = y;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("accept_timeout", 64'h0, 64'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        timing_on = timed;
        log_q.delete();
    endtask

    task automatic wait_rsp(output int l);
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) check("rsp_wait_timeout", 64'h0, 64'h1);
        l = lat;
    endtask

    task automatic release_rsp;
        @(negedge clk);
        rsp_ready = 1'b1;
        timing_on = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("ready_after_release", {63'h0, req_ready}, 64'h1);
        check("valid_after_release", {63'h0, rsp_valid}, 64'h0);
        check("busy_after_release", {63'h0, busy}, 64'h0);
    endtask

    task automatic check_txn(input int i, input logic we, input logic [31:0] adr, input logic [31:0] dat);
        if (log_q.size() > i) begin
            check("txn_we", {63'h0, log_q[i].we}, {63'h0, we});
            check("txn_adr", {32'h0, log_q[i].adr}, {32'h0, adr});
            check("txn_dat", {32'h0, log_q[i].dat}, {32'h0, dat});
        end else begin
            check("txn_present", 64'h0, 64'h1);
        end
    endtask

    task automatic run_good(input logic [31:0] x, input logic [31:0] y, input logic [63:0] exp_lit);
        int l;
        model_prod = {32'h0, x} * {32'h0, y};
        model_err  = 1'b0;
        accept_req(x, y, 1'b1);
        @(negedge clk);
        check("err_cleared_on_accept", {63'h0, rsp_err}, 64'h0);
        wait_rsp(l);
        check("latency", l, W + 10);
        check("prod_literal", rsp_prod, exp_lit);
        check("txn_count", log_q.size(), 4);
        check_txn(0, 1'b1, BASE, x);
        check_txn(1, 1'b1, BASE + 32'd4, y);
        check_txn(2, 1'b0, BASE + 32'd8, exp_lit[31:0]);
        check_txn(3, 1'b0, BASE + 32'd12, exp_lit[63:32]);
        release_rsp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int l;
        int n;
        int quiet_bad;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {63'h0, req_ready}, 64'h1);
        check("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_cyc", {63'h0, wbm_cyc_o}, 64'h0);
        check("rst_stb", {63'h0, wbm_stb_o}, 64'h0);
        check("rst_prod", rsp_prod, 64'h0);
        rst = 1'b0;

        run_good(32'd3, 32'd5, 64'h0F);
        run_good(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_good(32'h0, 32'hDEAD_BEEF, 64'h0);
        run_good(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);

        // backpressure: response held for 20 cycles
        model_prod = 64'd42;
        model_err  = 1'b0;
        accept_req(32'd7, 32'd6, 1'b1);
        wait_rsp(l);
        repeat (20) begin
            @(negedge clk);
            check("bp_valid", {63'h0, rsp_valid}, 64'h1);
            check("bp_prod", rsp_prod, 64'd42);
            check("bp_ready", {63'h0, req_ready}, 64'h0);
        end
        release_rsp();

        // stray ack in WAIT plus a request presented while busy
        stray_en   = 1'b1;
        model_prod = 64'd143;
        model_err  = 1'b0;
        accept_req(32'd11, 32'd13, 1'b1);
        @(negedge clk);
        req_x = 32'd99;
        req_y = 32'd99;
        req_valid = 1'b1;
        n = 0;
        while (lat < 50 && n < 200) begin
            @(negedge clk);
            check("busy_not_ready", {63'h0, req_ready}, 64'h0);
            n++;
        end
        req_valid = 1'b0;
        wait_rsp(l);
        check("stray_latency", l, W + 10);
        check("stray_prod", rsp_prod, 64'h8F);
        check("stray_txn_count", log_q.size(), 4);
        stray_en = 1'b0;
        release_rsp();

        // timeout: Y write never acknowledged
        mute_y       = 1'b1;
        model_prod   = 64'h0;
        model_err    = 1'b1;
        y_stb_cycles = 0;
        count_y      = 1'b1;
        accept_req(32'd21, 32'd2, 1'b0);
        wait_rsp(l);
        check("to_latency", l, 19);
        check("to_stb_cycles", y_stb_cycles, 16);
        check("to_cyc", {63'h0, wbm_cyc_o}, 64'h0);
        check("to_stb", {63'h0, wbm_stb_o}, 64'h0);
        check("to_err", {63'h0, rsp_err}, 64'h1);
        check("to_prod", rsp_prod, 64'h0);
        count_y = 1'b0;
        mute_y  = 1'b0;
        release_rsp();
        run_good(32'd2, 32'd9, 64'd18);

        // reset during WAIT
        accept_req(32'd5, 32'd5, 1'b1);
        n = 0;
        while (lat != 40 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #2;
        rst = 1'b1;
        timing_on = 1'b0;
        #1;
        check("rw_cyc", {63'h0, wbm_cyc_o}, 64'h0);
        check("rw_stb", {63'h0, wbm_stb_o}, 64'h0);
        check("rw_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        check("rw_req_ready", {63'h0, req_ready}, 64'h1);
        @(negedge clk);
        rst = 1'b0;

        // reset while the P0 read strobe is up
        accept_req(32'd5, 32'd5, 1'b1);
        n = 0;
        while (lat != W + 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rd_lo_stb_up", {63'h0, wbm_stb_o}, 64'h1);
        #2;
        rst = 1'b1;
        timing_on = 1'b0;
        #1;
        check("rr_cyc", {63'h0, wbm_cyc_o}, 64'h0);
        check("rr_stb", {63'h0, wbm_stb_o}, 64'h0);
        check("rr_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        log_q.delete();
        quiet_bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (wbm_cyc_o || wbm_stb_o) quiet_bad++;
        end
        check("quiet_after_reset", quiet_bad, 0);
        check("no_txn_after_reset", log_q.size(), 0);
        check("ready_after_reset", {63'h0, req_ready}, 64'h1);

        run_good(32'd6, 32'd7, 64'd42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spm_wb_driver.md
Name: spm_wb_driver

Overview:
- Wishbone classic initiator that drives the 32x32 serial-parallel multiplier peripheral on the user-area bus.
- Accepts a multiply request (X, Y) on a valid/ready port and performs the bus sequence: write X, write Y, wait for the serial computation, read the product low word, read the product high word.
- Returns the 64-bit product, or an error flag, on a valid/ready response port.
- Sits between a local controller or test harness and the peripheral's slave port, in the same clock domain.

Parameters:
- BASE_ADDR, 32'h3000_0000, address of the X register. Y is BASE+4, P0 (product low) is BASE+8, P1 (product high) is BASE+12.
- WAIT_CYCLES, 72, idle cycles between the Y-write ack and the P0 read. Must be >= 66 for the 64-cycle serial multiply.
- ACK_TIMEOUT, 16, maximum cycles with stb high and no ack before the transfer is aborted.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  multiply request present
- req_ready  out  1  driver idle, can accept a request
- req_x  in  32  multiplicand
- req_y  in  32  multiplier
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes the result
- rsp_prod  out  64  product {P1,P0}
- rsp_err  out  1  ack timeout occurred
- busy  out  1  high in any state other than IDLE
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  write enable
- wbm_sel_o  out  4  byte selects
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  acknowledge

Behaviour:
- Reset: rst is asynchronous, active-high; clk is the clock. Every output is registered and resets to 0, except req_ready, which resets to 1. State resets to IDLE.
- Reset during a bus cycle drops cyc/stb immediately. Any captured X/Y/product is discarded.
- States: IDLE, WR_X, WR_Y, WAIT, RD_LO, GAP, RD_HI, RESP.
- IDLE: req_ready=1. On an edge with req_valid&req_ready: latch req_x/req_y, go to WR_X, and assert cyc/stb/we=1, adr=BASE, dat=X.
- WR_X: on the edge where ack is sampled high: drop cyc/stb, go to GAP_X (one idle cycle), then WR_Y with adr=BASE+4, dat=Y, we=1. GAP_X is the GAP state reused, with a next-target register.
- WR_Y: on ack, drop cyc/stb, load the wait counter with WAIT_CYCLES, go to WAIT.
- WAIT: decrement the counter. When it reaches 0, go to RD_LO with cyc/stb=1, we=0, adr=BASE+8.
- RD_LO: on ack, capture wbm_dat_i into prod[31:0], drop stb, go to GAP (1 cycle), then RD_HI with adr=BASE+12.
- RD_HI: on ack, capture prod[63:32], drop stb, go to RESP.
- RESP: rsp_valid=1, and rsp_prod/rsp_err are held stable. On rsp_valid&rsp_ready, go to IDLE with rsp_valid=0.
- Outputs while idle: wbm_sel_o is always 4'hF. wbm_dat_o and wbm_we_o are 0 outside write states.
- ack is ignored unless stb is high. A stray ack in IDLE, WAIT or GAP has no effect.
- Zero-wait slave timing (ack registered one cycle after stb): each transfer holds stb for 2 cycles. rsp_valid rises exactly 10+WAIT_CYCLES clock edges after the accepting edge (82 at default).
- Timeout: a per-transfer counter is cleared when stb rises and increments each cycle stb is high without ack. On reaching ACK_TIMEOUT: drop cyc/stb, set rsp_err=1, rsp_prod=0, go to RESP.
- Error clearing: rsp_err is cleared when the next request is accepted.
- No pipelining: a request arriving while busy is not accepted (req_ready=0). The request must be held by its source.
- Product width: rsp_prod is exactly {P1,P0} as read; no arithmetic in the driver.

Decomposition:
- Package spm_wb_pkg holds:
  - the register offsets X_OFF=0, Y_OFF=4, P0_OFF=8, P1_OFF=12;
  - the state enum;
  - the default WAIT_CYCLES and ACK_TIMEOUT constants.
- One sub-module is natural: spm_wb_xfer, a single-transfer engine. It takes start/we/adr/dat, drives cyc/stb, and returns done/rdata/timeout. The top level is the sequencing FSM around it.

Test Plan:
- Basic product: req x=3, y=5, responsive slave model → writes to 0x30000000=3 and 0x30000004=5 in order; reads of 0x30000008 and 0x3000000C; rsp_prod=64'h0F; rsp_err=0; rsp_valid exactly 82 edges after accept.
- Maximum operands: x=y=32'hFFFFFFFF → rsp_prod=64'hFFFFFFFE_00000001. Also x=0, y=0xDEADBEEF → 0.
- Backpressure: hold rsp_ready=0 for 20 cycles → rsp_valid and rsp_prod stable throughout, req_ready=0. Release → IDLE the next cycle, req_ready=1.
- Timeout: slave never acks the Y write → stb high for exactly 16 cycles, then cyc/stb=0, rsp_valid=1, rsp_err=1, rsp_prod=0. The next good request clears rsp_err.
- Reset mid-operation: assert rst during WAIT and during RD_LO stb → cyc/stb/rsp_valid go 0 asynchronously, req_ready=1 after release, no further bus activity.
- Protocol checks: a stray ack injected during WAIT is ignored. A new req_valid while busy is not accepted. The bus monitor verifies stb is never high in GAP/WAIT and that sel=4'hF on every transfer.
